uart_rx_fifo_wr: RTL and testbench

UART_RX_FIFO_WR -- requirements
Module: uart_rx_fifo_wr

---
 rtl/uart_rx_fifo_wr_if.sv | 25 ++
 rtl/uart_rx_fifo_wr.sv | 152 +++++++++++++++
 tb/tb_uart_rx_fifo_wr.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_wr_if.sv
// Write-side bundle between the UART receiver and the downstream write FIFO,
// together with the receiver's status pulses.
interface uart_rx_fifo_wr_if;
  logic       wfifo_full;
  logic       wfifo_wr_en;
  logic [7:0] wfifo_wr_data;
  logic       frame_err;
  logic       ovf_flag;

  modport master (
    input  wfifo_full,
    output wfifo_wr_en,
    output wfifo_wr_data,
    output frame_err,
    output ovf_flag
  );

  modport slave (
    output wfifo_full,
    input  wfifo_wr_en,
    input  wfifo_wr_data,
    input  frame_err,
    input  ovf_flag
  );
endinterface

// File: rtl/uart_rx_fifo_wr.sv
// UART 8N1 receiver that pushes each good byte into a write FIFO.
// Optional stop-bit checking is enabled by defining UART_RX_STOP_CHK_EN;
// without it every stop sample counts as valid and frame_err stays 0.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a falling edge on the synchronized line
// START | running to mid start bit; line high there means glitch
// DATA  | sampling 8 data bits, one per bit-period tick, LSB first
// STOP  | sampling the stop bit on the next tick, then back to IDLE
module uart_rx_fifo_wr #(
  parameter int unsigned BAND_TIME = 5207
) (
  input  logic               s_clk,
  input  logic               s_rst,
  input  logic               data_rx,
  uart_rx_fifo_wr_if.master  wfifo
);

  localparam logic [12:0] TC   = 13'(BAND_TIME);
  localparam logic [12:0] HALF = 13'(BAND_TIME / 2);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state, state_nxt;
  logic        rx_s1, rx_s2, rx_h;
  logic [12:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_q;
  logic        start_edge, tick, half_hit, stop_ok;
  logic        cnt_clr, cnt_inc, shift_en, stop_smp;
  logic        wr_en_q, ovf_q;
  logic [7:0]  wr_data_q;

  assign start_edge = ~rx_s2 & rx_h;
  assign tick       = (baud_cnt == TC);
  assign half_hit   = (baud_cnt == HALF);

`ifdef UART_RX_STOP_CHK_EN
  assign stop_ok = rx_s2;
`else
  assign stop_ok = 1'b1;
`endif

  // Two-stage synchronizer plus history stage; resets to idle-high.
  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_h  <= 1'b1;
    end else begin
      rx_s1 <= data_rx;
      rx_s2 <= rx_s1;
      rx_h  <= rx_s2;
    end
  end

  // FSM state register.
  always_ff @(posedge s_clk) begin
    if (s_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start_edge) state_nxt = START;
      START: if (half_hit)   state_nxt = rx_s2 ? IDLE : DATA;
      DATA:  if (tick && (bit_cnt == 3'd7)) state_nxt = STOP;
      STOP:  if (tick)       state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // Per-state datapath controls.
  always_comb begin
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    shift_en = 1'b0;
    stop_smp = 1'b0;
    case (state)
      IDLE:  cnt_clr = start_edge;
      START: if (half_hit) cnt_clr = 1'b1; else cnt_inc = 1'b1;
      DATA: begin
        if (tick) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
        end else begin
          cnt_inc  = 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          cnt_clr  = 1'b1;
          stop_smp = 1'b1;
        end else begin
          cnt_inc  = 1'b1;
        end
      end
      default: cnt_clr = 1'b1;
    endcase
  end

  // Baud counter, bit counter and LSB-first shift register.
  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
    end else begin
      if (cnt_clr)      baud_cnt <= '0;
      else if (cnt_inc) baud_cnt <= baud_cnt + 13'd1;
      if (shift_en) begin
        shift_q <= {rx_s2, shift_q[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  // Write strobe / overflow pulse, registered one cycle after the stop sample.
  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      wr_en_q   <= 1'b0;
      ovf_q     <= 1'b0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= stop_smp & stop_ok & ~wfifo.wfifo_full;
      ovf_q   <= stop_smp & stop_ok &  wfifo.wfifo_full;
      if (stop_smp & stop_ok & ~wfifo.wfifo_full) wr_data_q <= shift_q;
    end
  end

`ifdef UART_RX_STOP_CHK_EN
  logic ferr_q;

  // Frame error pulse when the stop sample reads low.
  always_ff @(posedge s_clk) begin
    if (s_rst) ferr_q <= 1'b0;
    else       ferr_q <= stop_smp & ~rx_s2;
  end

  assign wfifo.frame_err = ferr_q;
`else
  assign wfifo.frame_err = 1'b0;
`endif

  assign wfifo.wfifo_wr_en   = wr_en_q;
  assign wfifo.wfifo_wr_data = wr_data_q;
  assign wfifo.ovf_flag      = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo_wr.sv
// Directed bench for uart_rx_fifo_wr at 16 clocks per bit. A queue of expected
// events (write/frame error/overflow) is filled as frames are sent and drained
// by a per-cycle compare process.
module tb_uart_rx_fifo_wr;

  localparam int BT  = 15;
  localparam int BIT = BT + 1;
  localparam int K_WR = 0, K_FERR = 1, K_OVF = 2;

  typedef struct {int kind; logic [7:0] data;} evt_t;

  logic s_clk = 1'b0;
  logic s_rst = 1'b1;
  logic data_rx = 1'b1;

  uart_rx_fifo_wr_if wfifo ();

  uart_rx_fifo_wr #(.BAND_TIME(BT)) dut (
    .s_clk   (s_clk),
    .s_rst   (s_rst),
    .data_rx (data_rx),
    .wfifo   (wfifo.master)
  );

  always #10 s_clk = ~s_clk;

  evt_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         evt_cyc = -1;
  int         n_wr = 0, n_ferr = 0, n_ovf = 0;
  int         frame_start = 0;
  logic [7:0] last_data = 8'h00;
  bit         prev_any = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Per-cycle compare against the expected event queue.
  initial begin
    evt_t e;
    int   n;
    forever begin
      @(posedge s_clk);
      cyc++;
      #1;
      if (s_rst) begin
        chk("rst_outputs", {wfifo.wfifo_wr_en, wfifo.frame_err, wfifo.ovf_flag, wfifo.wfifo_wr_data}, 32'h0);
        last_data = 8'h00;
        prev_any  = 1'b0;
      end else begin
        n = int'(wfifo.wfifo_wr_en) + int'(wfifo.frame_err) + int'(wfifo.ovf_flag);
        chk("pulse_exclusive", (n > 1), 0);
        if (n > 0) chk("pulse_back_to_back", prev_any, 0);
        if (n > 0) begin
          evt_cyc = cyc;
          if (exp_q.size() == 0) begin
            chk("unexpected_event", n, 0);
          end else begin
            e = exp_q.pop_front();
            chk("event_kind",
                wfifo.wfifo_wr_en ? K_WR : (wfifo.frame_err ? K_FERR : K_OVF), e.kind);
            if (wfifo.wfifo_wr_en) chk("write_data", wfifo.wfifo_wr_data, e.data);
          end
          if (wfifo.wfifo_wr_en) n_wr++;
          if (wfifo.frame_err)   n_ferr++;
          if (wfifo.ovf_flag)    n_ovf++;
        end
        if (wfifo.wfifo_wr_en) last_data = wfifo.wfifo_wr_data;
        else                   chk("data_hold", wfifo.wfifo_wr_data, last_data);
        prev_any = (n > 0);
      end
    end
  end

  task automatic hold_line(input logic v, input int n);
    data_rx = v;
    repeat (n) @(negedge s_clk);
  endtask

  task automatic expect_frame(input logic [7:0] b, input logic stop_v);
    evt_t e;
    logic valid;
`ifdef UART_RX_STOP_CHK_EN
    valid = stop_v;
`else
    valid = 1'b1;
`endif
    e.data = b;
    if (!valid)                 e.kind = K_FERR;
    else if (wfifo.wfifo_full)  e.kind = K_OVF;
    else                        e.kind = K_WR;
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v);
    expect_frame(b, stop_v);
    frame_start = cyc;
    hold_line(1'b0, BIT);
    for (int i = 0; i < 8; i++) hold_line(b[i], BIT);
    hold_line(stop_v, BIT);
    data_rx = 1'b1;
  endtask

  task automatic drained(input string name);
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    logic [7:0] c6;
    wfifo.wfifo_full = 1'b0;
    repeat (3) @(negedge s_clk);
    s_rst = 1'b0;
    hold_line(1'b1, 20);

    // Single byte, literal pins on data and latency from start-bit edge.
    send_frame(8'h55, 1'b1);
    hold_line(1'b1, 20);
    drained("drain_55");
    chk("lit_data_55", wfifo.wfifo_wr_data, 8'h55);
    chk("lit_latency", evt_cyc - frame_start, 155);

    // Back-to-back bytes, no idle gap.
    send_frame(8'hA3, 1'b1);
    send_frame(8'h0F, 1'b1);
    hold_line(1'b1, 20);
    drained("drain_a3_0f");
    chk("lit_data_0f", wfifo.wfifo_wr_data, 8'h0F);

    // Short low glitch on idle line: nothing must come out.
    hold_line(1'b0, 4);
    hold_line(1'b1, 40);
    drained("drain_glitch");

    // Bad stop bit, then line held low for a while before returning high.
    send_frame(8'h3C, 1'b0);
    hold_line(1'b0, 3 * BIT);
    hold_line(1'b1, 40);
    drained("drain_3c");

    // Overflow on a full FIFO, then a normal write.
    wfifo.wfifo_full = 1'b1;
    send_frame(8'h81, 1'b1);
    hold_line(1'b1, 10);
    wfifo.wfifo_full = 1'b0;
    send_frame(8'h7E, 1'b1);
    hold_line(1'b1, 20);
    drained("drain_81_7e");
    chk("lit_data_7e", wfifo.wfifo_wr_data, 8'h7E);

    // Reset in the middle of data bit 4 of 0xC6, then 0x12.
    c6 = 8'hC6;
    hold_line(1'b0, BIT);
    for (int i = 0; i < 4; i++) hold_line(c6[i], BIT);
    hold_line(c6[4], BIT / 2);
    s_rst = 1'b1;
    @(negedge s_clk);
    s_rst = 1'b0;
    hold_line(1'b1, 2 * BIT);
    chk("lit_data_after_rst", wfifo.wfifo_wr_data, 8'h00);
    send_frame(8'h12, 1'b1);
    hold_line(1'b1, 30);
    drained("drain_12");
    chk("lit_data_12", wfifo.wfifo_wr_data, 8'h12);

`ifdef UART_RX_STOP_CHK_EN
    chk("lit_n_wr", n_wr, 5);
    chk("lit_n_ferr", n_ferr, 1);
`else
    chk("lit_n_wr", n_wr, 6);
    chk("lit_n_ferr", n_ferr, 0);
`endif
    chk("lit_n_ovf", n_ovf, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
